bomb_bcd_counter: RTL and testbench

Parametrised multi-digit BCD up/down counter for the bomb controller countdown. Generalises the plain binary load/increment/decrement register to DIGITS decimal digits; each digit independently counts mod 10 or mod 6, so one instance holds an mm:ss timer. It sits between the controller FSM, which issues ctrl and data_in, and the display/detonation logic, which consumes data_out, zero, full and bound.

---
 rtl/bomb_pkg.sv | 22 ++
 rtl/bomb_bcd_digit.sv | 39 +++
 rtl/bomb_bcd_counter.sv | 83 ++++++++
 tb/tb_bomb_bcd_counter.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/bomb_pkg.sv
// ==== bomb_pkg : shared ctrl encoding, BCD limits, load clamp (rev 1.0) ====
`default_nettype none

package bomb_pkg;

  localparam logic [1:0] CTRL_NONE = 2'd0;
  localparam logic [1:0] CTRL_LOAD = 2'd1;
  localparam logic [1:0] CTRL_INCR = 2'd2;
  localparam logic [1:0] CTRL_DECR = 2'd3;

  localparam logic [3:0] BCD_MAX_DEC  = 4'd9;
  localparam logic [3:0] BCD_MAX_SEXA = 4'd5;

  function automatic logic [3:0] bcd_clamp(input logic [3:0] d, input logic sexa);
    logic [3:0] m;
    m = sexa ? BCD_MAX_SEXA : BCD_MAX_DEC;
    return (d > m) ? m : d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bomb_bcd_digit.sv
// ==== bomb_bcd_digit : one mod-10 / mod-6 digit of the ripple chain (rev 1.0) ====
`default_nettype none

module bomb_bcd_digit
  import bomb_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       is_sexa,
  input  logic       inc_in,
  input  logic       dec_in,
  output logic [3:0] next_digit,
  output logic       carry_out,
  output logic       borrow_out,
  output logic       is_max,
  output logic       is_zero
);

  logic [3:0] max_val;

  assign max_val = is_sexa ? BCD_MAX_SEXA : BCD_MAX_DEC;
  assign is_max  = (digit == max_val);
  assign is_zero = (digit == 4'd0);

  always_comb begin
    next_digit = digit;
    carry_out  = 1'b0;
    borrow_out = 1'b0;
    if (inc_in) begin
      next_digit = is_max ? 4'd0 : digit + 4'd1;
      carry_out  = is_max;
    end else if (dec_in) begin
      next_digit = is_zero ? max_val : digit - 4'd1;
      borrow_out = is_zero;
    end
  end

endmodule

`default_nettype wire

// File: rtl/bomb_bcd_counter.sv
// ==== bomb_bcd_counter : DIGITS-digit BCD load/up/down counter (rev 1.0) ====
// Define BOMB_BCD_SATURATE_EN to block at the limits instead of wrapping.
`default_nettype none

module bomb_bcd_counter
  import bomb_pkg::*;
#(
  parameter int                DIGITS    = 4,
  parameter logic [DIGITS-1:0] SEXA_MASK = 4'b0010
) (
  input  logic                  clk,
  input  logic                  async_nreset,
  input  logic [1:0]            ctrl,
  input  logic [4*DIGITS-1:0]   data_in,
  output logic [4*DIGITS-1:0]   data_out,
  output logic                  zero,
  output logic                  full,
  output logic                  bound
);

  logic [4*DIGITS-1:0] cnt, cnt_nxt, arith, load_val;
  logic [DIGITS:0]     carry, borrow;
  logic [DIGITS-1:0]   dig_max, dig_zero;
  logic                bound_q, bound_nxt, wrap;

  assign carry[0]  = (ctrl == CTRL_INCR);
  assign borrow[0] = (ctrl == CTRL_DECR);

  generate
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      bomb_bcd_digit u_digit (
        .digit      (cnt[4*i +: 4]),
        .is_sexa    (SEXA_MASK[i]),
        .inc_in     (carry[i]),
        .dec_in     (borrow[i]),
        .next_digit (arith[4*i +: 4]),
        .carry_out  (carry[i+1]),
        .borrow_out (borrow[i+1]),
        .is_max     (dig_max[i]),
        .is_zero    (dig_zero[i])
      );
      assign load_val[4*i +: 4] = bcd_clamp(data_in[4*i +: 4], SEXA_MASK[i]);
    end
  endgenerate

  // A carry or borrow escaping the top digit is exactly the boundary event.
  assign wrap = carry[DIGITS] | borrow[DIGITS];

  always_comb begin
    cnt_nxt   = cnt;
    bound_nxt = 1'b0;
    case (ctrl)
      CTRL_LOAD: cnt_nxt = load_val;
      CTRL_INCR, CTRL_DECR: begin
        bound_nxt = wrap;
`ifdef BOMB_BCD_SATURATE_EN
        cnt_nxt   = wrap ? cnt : arith;
`else
        cnt_nxt   = arith;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      cnt     <= '0;
      bound_q <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      bound_q <= bound_nxt;
    end
  end

  assign data_out = cnt;
  assign zero     = &dig_zero;
  assign full     = &dig_max;
  assign bound    = bound_q;

endmodule

`default_nettype wire

// File: tb/tb_bomb_bcd_counter.sv
// ==== tb_bomb_bcd_counter : directed vectors for the mm:ss BCD counter (rev 1.0) ====
`default_nettype none

module tb_bomb_bcd_counter;

  localparam logic [1:0] NONE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] INCR = 2'd2;
  localparam logic [1:0] DECR = 2'd3;

  logic        clk = 1'b0;
  logic        async_nreset = 1'b0;
  logic [1:0]  ctrl = NONE;
  logic [15:0] data_in = 16'h0000;
  logic [15:0] data_out;
  logic        zero, full, bound;

  int n_vec  = 0;
  int n_miss = 0;

  bomb_bcd_counter #(.DIGITS(4), .SEXA_MASK(4'b0010)) dut (
    .clk          (clk),
    .async_nreset (async_nreset),
    .ctrl         (ctrl),
    .data_in      (data_in),
    .data_out     (data_out),
    .zero         (zero),
    .full         (full),
    .bound        (bound)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  c;
    logic [15:0] d;
    logic [15:0] q;
    logic        z;
    logic        f;
    logic        b;
  } vec_t;

  vec_t vt[14];

  task automatic check(input string nm, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic check_all(input string nm, input logic [15:0] q, input logic z,
                           input logic f, input logic b);
    check({nm, ".data_out"}, data_out, q);
    check({nm, ".zero"}, {15'd0, zero}, {15'd0, z});
    check({nm, ".full"}, {15'd0, full}, {15'd0, f});
    check({nm, ".bound"}, {15'd0, bound}, {15'd0, b});
  endtask

  task automatic step(input logic [1:0] c, input logic [15:0] d);
    @(negedge clk);
    ctrl    = c;
    data_in = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vt[0]  = '{LOAD, 16'h1000, 16'h1000, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{DECR, 16'h0000, 16'h0959, 1'b0, 1'b0, 1'b0};
    vt[2]  = '{LOAD, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0};
    vt[3]  = '{DECR, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0};
`ifdef BOMB_BCD_SATURATE_EN
    vt[4]  = '{DECR, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1};
    vt[5]  = '{NONE, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0};
    vt[6]  = '{LOAD, 16'h9959, 16'h9959, 1'b0, 1'b1, 1'b0};
    vt[7]  = '{INCR, 16'h0000, 16'h9959, 1'b0, 1'b1, 1'b1};
`else
    vt[4]  = '{DECR, 16'h0000, 16'h9959, 1'b0, 1'b1, 1'b1};
    vt[5]  = '{NONE, 16'h0000, 16'h9959, 1'b0, 1'b1, 1'b0};
    vt[6]  = '{LOAD, 16'h9959, 16'h9959, 1'b0, 1'b1, 1'b0};
    vt[7]  = '{INCR, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1};
`endif
    vt[8]  = '{LOAD, 16'hAB7C, 16'h9959, 1'b0, 1'b1, 1'b0};
    vt[9]  = '{LOAD, 16'h0069, 16'h0059, 1'b0, 1'b0, 1'b0};
    vt[10] = '{INCR, 16'h0000, 16'h0100, 1'b0, 1'b0, 1'b0};
    vt[11] = '{DECR, 16'h0000, 16'h0059, 1'b0, 1'b0, 1'b0};
    vt[12] = '{LOAD, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0};
    vt[13] = '{INCR, 16'h1234, 16'h0001, 1'b0, 1'b0, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 16'h0000, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    async_nreset = 1'b1;

    for (int i = 0; i < 14; i++) begin
      step(vt[i].c, vt[i].d);
      check_all($sformatf("vec%0d", i), vt[i].q, vt[i].z, vt[i].f, vt[i].b);
    end

    // asynchronous reset in the middle of a cycle
    step(LOAD, 16'h0530);
    check("mid_load", data_out, 16'h0530);
    #2 async_nreset = 1'b0;
    #1 check_all("mid_reset", 16'h0000, 1'b1, 1'b0, 1'b0);
    #1 async_nreset = 1'b1;

    // long countdown stays clear of the boundary
    step(LOAD, 16'h1000);
    step(DECR, 16'h0000);
    check("dec1", data_out, 16'h0959);
    for (int k = 0; k < 59; k++) begin
      step(DECR, 16'h0000);
      check("dec_zero", {15'd0, zero}, 16'h0000);
      check("dec_bound", {15'd0, bound}, 16'h0000);
    end
    check("dec59", data_out, 16'h0900);

    // held INCR counts once per clock, then NONE holds
    step(LOAD, 16'h0000);
    @(negedge clk);
    ctrl = INCR;
    repeat (61) @(posedge clk);
    #1;
    check_all("hold_incr", 16'h0101, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    ctrl = NONE;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check("none_hold", data_out, 16'h0101);
      check("none_bound", {15'd0, bound}, 16'h0000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
